// File: rtl/ifm_axis_out.sv
// ifm_axis_out: RX interface-manager output stage.
// Each frame is sent in two parts, always in this order:
//   1. The good-frame FIFO contents go onto the S2MM data stream.
//   2. The frame's control words from the ctrl FIFO go onto the S2MM status stream.
// Both FIFOs are first-word-fall-through (FWFT): the head word is visible before it is popped.
// A status packet is cut off at C_STS_WORDS words. Any surplus words are flushed.
// A status packet that is too short or too long sets the sticky sts_err flag.
// Optional build macro IFM_AXIS_OUT_REG_EN: the data stream is driven from a 2-entry skid
// register slice instead of combinationally from the FIFO head.
module ifm_axis_out #(
  parameter int C_STS_WORDS = 6,
  parameter int C_FRM_CNT_W = 16
) (
  input  logic                   s2mm_clk,
  input  logic                   s2mm_resetn,
  input  logic [72:0]            good_fifo_rdata,
  input  logic                   good_fifo_empty,
  output logic                   good_fifo_rden,
  input  logic [36:0]            ctrl_fifo_rdata,
  input  logic                   ctrl_fifo_empty,
  output logic                   ctrl_fifo_rden,
  output logic [63:0]            s2mm_tdata,
  output logic [7:0]             s2mm_tkeep,
  output logic                   s2mm_tlast,
  output logic                   s2mm_tvalid,
  input  logic                   s2mm_tready,
  output logic [31:0]            s2mm_sts_tdata,
  output logic [3:0]             s2mm_sts_tkeep,
  output logic                   s2mm_sts_tlast,
  output logic                   s2mm_sts_tvalid,
  input  logic                   s2mm_sts_tready,
  output logic [C_FRM_CNT_W-1:0] frame_cnt,
  output logic                   sts_err,
  output logic [3:0]             ifm_axis_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_STS   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  localparam logic [3:0] WLAST = 4'(C_STS_WORDS - 1);

  state_t                 state_q;
  logic [3:0]             wcnt_q;
  logic [C_FRM_CNT_W-1:0] frame_cnt_q;
  logic                   sts_err_q;

  // data_done: the beat carrying tlast was accepted downstream.
  logic data_done;
  logic ctrl_last;
  logic wcnt_at_last;
  logic sts_vld;
  logic sts_hs;

  assign ctrl_last    = ctrl_fifo_rdata[36];
  assign wcnt_at_last = (wcnt_q == WLAST);

  // Status stream is combinational from the ctrl FIFO head.
  // tlast is forced on the final allowed word even if the packet lacks its own last marker.
  assign sts_vld         = (state_q == S_STS) & ~ctrl_fifo_empty;
  assign sts_hs          = sts_vld & s2mm_sts_tready;
  assign s2mm_sts_tvalid = sts_vld;
  assign s2mm_sts_tdata  = ctrl_fifo_rdata[31:0];
  assign s2mm_sts_tkeep  = ctrl_fifo_rdata[35:32];
  assign s2mm_sts_tlast  = sts_vld & (ctrl_last | wcnt_at_last);
  assign ctrl_fifo_rden  = sts_hs | ((state_q == S_FLUSH) & ~ctrl_fifo_empty);

`ifdef IFM_AXIS_OUT_REG_EN
  // Skid slice: out_* is the presented beat, skid_* catches one extra beat.
  // The FIFO pop decision looks only at registered occupancy, so it never waits on tready.
  logic        out_vld_q, out_vld_d;
  logic        skid_vld_q, skid_vld_d;
  logic        last_in_q, last_in_d;
  logic [72:0] out_word_q, out_word_d;
  logic [72:0] skid_word_q, skid_word_d;
  logic        pop_en;
  logic        out_take;

  // Next-state for the skid slice and the tlast-already-popped flag.
  always_comb begin
    pop_en      = (state_q == S_DATA) & ~good_fifo_empty & ~last_in_q
                  & ~(out_vld_q & skid_vld_q);
    out_take    = ~out_vld_q | s2mm_tready;
    out_vld_d   = out_vld_q;
    out_word_d  = out_word_q;
    skid_vld_d  = skid_vld_q;
    skid_word_d = skid_word_q;
    last_in_d   = last_in_q;
    if (out_take) begin
      out_vld_d  = skid_vld_q | pop_en;
      out_word_d = skid_vld_q ? skid_word_q : good_fifo_rdata;
      skid_vld_d = skid_vld_q & pop_en;
      if (skid_vld_q & pop_en) begin
        skid_word_d = good_fifo_rdata;
      end
    end else if (pop_en) begin
      skid_vld_d  = 1'b1;
      skid_word_d = good_fifo_rdata;
    end
    if (data_done) begin
      last_in_d = 1'b0;
    end else if (pop_en & good_fifo_rdata[72]) begin
      last_in_d = 1'b1;
    end
  end

  // Slice control flops; a reset drops any partially buffered frame.
  always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
    if (!s2mm_resetn) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      last_in_q  <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      last_in_q  <= last_in_d;
    end
  end

  // Slice payload flops, qualified by the valid bits above.
  always_ff @(posedge s2mm_clk) begin
    out_word_q  <= out_word_d;
    skid_word_q <= skid_word_d;
  end

  assign good_fifo_rden = pop_en;
  assign s2mm_tvalid    = out_vld_q;
  assign s2mm_tdata     = out_word_q[63:0];
  assign s2mm_tkeep     = out_word_q[71:64];
  assign s2mm_tlast     = out_vld_q & out_word_q[72];
  assign data_done      = out_vld_q & s2mm_tready & out_word_q[72];
`else
  // Zero-latency data path straight from the FWFT head.
  logic data_vld;

  assign data_vld       = (state_q == S_DATA) & ~good_fifo_empty;
  assign good_fifo_rden = data_vld & s2mm_tready;
  assign s2mm_tvalid    = data_vld;
  assign s2mm_tdata     = good_fifo_rdata[63:0];
  assign s2mm_tkeep     = good_fifo_rdata[71:64];
  assign s2mm_tlast     = data_vld & good_fifo_rdata[72];
  assign data_done      = good_fifo_rden & good_fifo_rdata[72];
`endif

  // Frame sequencer: data phase, status phase, and recovery from over-long status packets.
  always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
    if (!s2mm_resetn) begin
      state_q     <= S_IDLE;
      wcnt_q      <= 4'd0;
      frame_cnt_q <= '0;
      sts_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!good_fifo_empty) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (data_done) begin
            state_q <= S_STS;
          end
        end
        S_STS: begin
          if (sts_hs) begin
            if (ctrl_last | wcnt_at_last) begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
              wcnt_q      <= 4'd0;
              if (ctrl_last) begin
                state_q <= S_IDLE;
                if (!wcnt_at_last) begin
                  sts_err_q <= 1'b1;
                end
              end else begin
                sts_err_q <= 1'b1;
                state_q   <= S_FLUSH;
              end
            end else begin
              wcnt_q <= wcnt_q + 4'd1;
            end
          end
        end
        S_FLUSH: begin
          if (!ctrl_fifo_empty && ctrl_last) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign frame_cnt    = frame_cnt_q;
  assign sts_err      = sts_err_q;
  assign ifm_axis_dbg = {good_fifo_empty, 1'b0, state_q};

endmodule
